// File: rtl/rec_patron_baba_ctrl.sv
// Scan controller for the serial "baba" (1010) recognizer: latches a word on start,
// shifts it MSB-first through an overlapping Moore recognizer and reports the match count.
module rec_patron_baba_ctrl #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              entrada,
    output logic              salida
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_t;

    typedef enum logic [2:0] {
        S0     = 3'd0,
        S_B    = 3'd1,
        S_BA   = 3'd2,
        S_BAB  = 3'd3,
        S_BABA = 3'd4
    } rec_t;

    ctrl_t             ctrl_q, ctrl_nxt;
    rec_t              rec_q, rec_nxt;
    logic [WORD_W-1:0] shreg_q, shreg_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              salida_q, salida_nxt;

    // Overlapping 1010 transition table; a completed match keeps its trailing "10"
    function automatic rec_t rec_step(input rec_t s, input logic x);
        rec_t n;
        n = S0;
        case (s)
            S0:      n = x ? S_B   : S0;
            S_B:     n = x ? S_B   : S_BA;
            S_BA:    n = x ? S_BAB : S0;
            S_BAB:   n = x ? S_B   : S_BABA;
            S_BABA:  n = x ? S_BAB : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q   <= IDLE;
            rec_q    <= S0;
            shreg_q  <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            salida_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_nxt;
            rec_q    <= rec_nxt;
            shreg_q  <= shreg_nxt;
            idx_q    <= idx_nxt;
            count_q  <= count_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            salida_q <= salida_nxt;
        end
    end

    always_comb begin
        ctrl_nxt  = ctrl_q;
        rec_nxt   = rec_q;
        shreg_nxt = shreg_q;
        idx_nxt   = idx_q;
        count_nxt = count_q;

        case (ctrl_q)
            IDLE: begin
                if (start) begin
                    shreg_nxt = data_in;
                    count_nxt = '0;
                    idx_nxt   = '0;
                    rec_nxt   = S0;
                    ctrl_nxt  = RUN;
                end
            end
            RUN: begin
                rec_nxt   = rec_step(rec_q, shreg_q[WORD_W-1]);
                shreg_nxt = {shreg_q[WORD_W-2:0], 1'b0};
                idx_nxt   = idx_q + IDX_W'(1);
                // Counter saturates instead of wrapping
                if (rec_nxt == S_BABA && count_q != CNT_MAX) begin
                    count_nxt = count_q + CNT_W'(1);
                end
                if (idx_q == IDX_W'(WORD_W - 1)) begin
                    ctrl_nxt = DONE;
                end
            end
            DONE:    ctrl_nxt = IDLE;
            default: ctrl_nxt = IDLE;
        endcase

        busy_nxt   = (ctrl_nxt != IDLE);
        done_nxt   = (ctrl_nxt == DONE);
        salida_nxt = (rec_nxt == S_BABA);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign count   = count_q;
    assign entrada = shreg_q[WORD_W-1];
    assign salida  = salida_q;

endmodule

// File: tb/tb_rec_patron_baba_ctrl.sv
// Bench for rec_patron_baba_ctrl: vector table plus hand sequences, with a done-driven
// scoreboard checking a default build and a CNT_W=2 build sharing the same stimulus.
module tb_rec_patron_baba_ctrl;

    localparam int unsigned W   = 16;
    localparam int unsigned CW  = 5;
    localparam int unsigned CW2 = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  data_in;
    logic          busy, done, entrada, salida;
    logic [CW-1:0] count;
    logic          busy2, done2, entrada2, salida2;
    logic [CW2-1:0] count2;

    rec_patron_baba_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .count(count), .entrada(entrada), .salida(salida)
    );

    rec_patron_baba_ctrl #(.WORD_W(W), .CNT_W(CW2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .busy(busy2), .done(done2), .count(count2), .entrada(entrada2), .salida(salida2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           exp_cnt;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   q_main[$];
    int   q_small[$];
    int   done_times[$];
    logic done_prev = 1'b0;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Independent reference: slide a 4-bit window over the word, MSB first
    function automatic int ref_count(input logic [W-1:0] w);
        int c;
        logic [3:0] win;
        c = 0;
        for (int i = 0; i <= int'(W) - 4; i++) begin
            win = w[W-1-i -: 4];
            if (win == 4'b1010) c++;
        end
        return c;
    endfunction

    function automatic int sat(input int c, input int cw);
        int mx;
        mx = (1 << cw) - 1;
        return (c > mx) ? mx : c;
    endfunction

    // Scoreboard: every done pulse must match a pending accepted start
    always @(negedge clk) begin
        int e;
        if (done) begin
            done_times.push_back(cyc);
            if (q_main.size() == 0) check("done_without_start", done, 0);
            else begin
                e = q_main.pop_front();
                check("count_at_done", count, e);
            end
            if (done_prev) check("done_one_cycle", done_prev, 0);
        end
        if (done2) begin
            if (q_small.size() == 0) check("sat_done_without_start", done2, 0);
            else begin
                e = q_small.pop_front();
                check("sat_count_at_done", count2, e);
            end
        end
        if (done || done2) check("sat_done_aligned", done2, done);
        done_prev = done;
    end

    task automatic do_scan(input logic [W-1:0] d, input int exp);
        logic [W-1:0] seen;
        int sal_hi, busy_bad, done_early;
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        q_main.push_back(sat(exp, CW));
        q_small.push_back(sat(exp, CW2));
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = W'($urandom);
        seen = '0; sal_hi = 0; busy_bad = 0; done_early = 0;
        for (int k = 1; k <= int'(W) + 1; k++) begin
            @(negedge clk);
            if (k <= int'(W)) seen = {seen[W-2:0], entrada};
            if (k >= 2 && salida) sal_hi++;
            if (!busy) busy_bad++;
            if (k <= int'(W) && done) done_early++;
        end
        check("done_after_last_bit", done, 1);
        check("entrada_msb_first", seen, d);
        check("salida_high_cycles", sal_hi, exp);
        check("busy_low_in_scan", busy_bad, 0);
        check("done_early", done_early, 0);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_after_done", done, 0);
    endtask

    initial begin
        logic [W-1:0] w;
        vecs[0] = '{16'hAAAA, 7};
        vecs[1] = '{16'h0000, 0};
        vecs[2] = '{16'hFFFF, 0};
        vecs[3] = '{16'hA0A0, 2};
        vecs[4] = '{16'h000A, 1};
        vecs[5] = '{16'h5555, 6};

        rst_n = 1'b0; start = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_entrada", entrada, 0);
        check("rst_salida", salida, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) do_scan(vecs[i].data, vecs[i].exp_cnt);
        for (int i = 0; i < 4; i++) begin
            w = W'($urandom);
            do_scan(w, ref_count(w));
        end

        // start held high with data changing each cycle: only IDLE-latched words scan
        @(negedge clk);
        done_times.delete();
        for (int n = 0; n < 3 * (int'(W) + 2); n++) begin
            w = W'($urandom);
            start = 1'b1;
            data_in = w;
            if (n % (int'(W) + 2) == 0) begin
                q_main.push_back(sat(ref_count(w), CW));
                q_small.push_back(sat(ref_count(w), CW2));
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int t = 0; t < 4 * int'(W) && q_main.size() != 0; t++) @(negedge clk);
        check("held_start_drain", q_main.size(), 0);
        check("held_start_done_count", done_times.size(), 3);
        if (done_times.size() >= 3) begin
            check("held_start_period_1", done_times[1] - done_times[0], W + 2);
            check("held_start_period_2", done_times[2] - done_times[1], W + 2);
        end

        // Reset mid-scan at index 8: partial result discarded, no done
        @(negedge clk);
        start = 1'b1;
        data_in = 16'hAAAA;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_count", count, 0);
        check("midrst_salida", salida, 0);
        check("midrst_done", done, 0);
        check("midrst_sat_count", count2, 0);
        repeat (W + 4) @(negedge clk);
        do_scan(16'hAAAA, 7);
        check("final_queue_empty", q_main.size() + q_small.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
